pe_conv_mac_stream: RTL and testbench

PE_CONV_MAC_STREAM -- requirements
Module: pe_conv_mac_stream

---
 rtl/pe_conv_pkg.sv | 7 +
 rtl/pe_conv_mac_stream_wmem.sv | 59 +++++
 rtl/pe_conv_mac_stream.sv | 132 +++++++++++++
 tb/tb_pe_conv_mac_stream.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_conv_pkg.sv
// pe_conv_pkg: shared FSM state, activation encodings and bias lane width
package pe_conv_pkg;
  typedef enum logic [1:0] {IDLE, CALC, POST, OUT} state_t;
  localparam logic [1:0] ACT_LINEAR = 2'd0;
  localparam logic [1:0] ACT_RELU = 2'd1;
  localparam int BIAS_W = 32;
endpackage

// File: rtl/pe_conv_mac_stream_wmem.sv
// pe_conv_mac_stream_wmem: weight/bias word store with one group-pixel read per cycle
module pe_conv_mac_stream_wmem
  import pe_conv_pkg::*;
#(
  parameter int pDATA_WIDTH = 8,
  parameter int pIN_CHANNEL = 1,
  parameter int pOUT_CHANNEL = 32,
  parameter int pKERNEL_SIZE = 3,
  parameter int pOUTPUT_PARALLEL = 8,
  parameter int pWEIGHT_DATA_WIDTH = 64,
  parameter logic [31:0] pWEIGHT_BASE_ADDR = 32'h4000_0000,
  parameter int pACC_WIDTH = 32,
  parameter int GW = 2,
  parameter int PW = 4
) (
  input  logic clk,
  input  logic we,
  input  logic [31:0] waddr,
  input  logic [pWEIGHT_DATA_WIDTH-1:0] wdata,
  input  logic [GW-1:0] g,
  input  logic [PW-1:0] p,
  output logic [pOUTPUT_PARALLEL*pIN_CHANNEL*pDATA_WIDTH-1:0] w,
  output logic [pOUTPUT_PARALLEL*pACC_WIDTH-1:0] b
);
  localparam int DW = pDATA_WIDTH;
  localparam int IC = pIN_CHANNEL;
  localparam int OP = pOUTPUT_PARALLEL;
  localparam int ACC = pACC_WIDTH;
  localparam int KK = pKERNEL_SIZE * pKERNEL_SIZE;
  localparam int L = pWEIGHT_DATA_WIDTH / DW;
  localparam int BL = pWEIGHT_DATA_WIDTH / BIAS_W;
  localparam int NW = pOUT_CHANNEL * IC * KK / L;
  localparam int NT = NW + pOUT_CHANNEL / BL;
  localparam int AW = $clog2(NT);
  logic [pWEIGHT_DATA_WIDTH-1:0] mem [NT];
  logic [31:0] off;
  int idx, bidx;
  logic signed [BIAS_W-1:0] bw;
  assign off = waddr - pWEIGHT_BASE_ADDR;
  always_ff @(posedge clk)
    if (we && off < 32'(NT)) mem[off[AW-1:0]] <= wdata;
  // the OP*IC weights for one (group, pixel) are contiguous in flat index order
  always_comb begin
    w = '0;
    b = '0;
    idx = 0;
    bidx = 0;
    bw = '0;
    for (int i = 0; i < OP * IC; i++) begin
      idx = (int'(g) * KK + int'(p)) * OP * IC + i;
      w[i*DW +: DW] = mem[AW'(idx / L)][(idx % L)*DW +: DW];
    end
    for (int o = 0; o < OP; o++) begin
      bidx = int'(g) * OP + o;
      bw = mem[AW'(NW + bidx / BL)][(bidx % BL)*BIAS_W +: BIAS_W];
      b[o*ACC +: ACC] = ACC'(bw);
    end
  end
endmodule

// File: rtl/pe_conv_mac_stream.sv
// pe_conv_mac_stream: streaming conv window MAC, one output-channel group per K*K+1 cycles
module pe_conv_mac_stream
  import pe_conv_pkg::*;
#(
  parameter int pDATA_WIDTH = 8,
  parameter int pIN_CHANNEL = 1,
  parameter int pOUT_CHANNEL = 32,
  parameter int pKERNEL_SIZE = 3,
  parameter int pOUTPUT_PARALLEL = 8,
  parameter int pWEIGHT_DATA_WIDTH = 64,
  parameter logic [31:0] pWEIGHT_BASE_ADDR = 32'h4000_0000,
  parameter int pACC_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load_weight,
  input  logic [31:0] weight_addr,
  input  logic [pWEIGHT_DATA_WIDTH-1:0] weight_data,
  input  logic [1:0] act_mode,
  input  logic [4:0] quant_shift,
  input  logic in_valid,
  output logic in_ready,
  input  logic [pDATA_WIDTH*pIN_CHANNEL*pKERNEL_SIZE*pKERNEL_SIZE-1:0] data_in,
  output logic out_valid,
  input  logic out_ready,
  output logic [pDATA_WIDTH*pOUT_CHANNEL-1:0] data_out,
  output logic busy
);
  localparam int DW = pDATA_WIDTH;
  localparam int IC = pIN_CHANNEL;
  localparam int OP = pOUTPUT_PARALLEL;
  localparam int ACC = pACC_WIDTH;
  localparam int KK = pKERNEL_SIZE * pKERNEL_SIZE;
  localparam int G = pOUT_CHANNEL / OP;
  localparam int GW = $clog2(G + 1);
  localparam int PW = $clog2(KK + 1);
  localparam logic signed [ACC:0] SMAX = (ACC+1)'(2 ** (DW - 1) - 1);
  localparam logic signed [ACC:0] SMIN = -SMAX - 1;
  state_t state;
  logic [GW-1:0] g;
  logic [PW-1:0] p;
  logic signed [ACC-1:0] acc [OP];
  logic signed [ACC-1:0] psum [OP];
  logic [DW-1:0] res [OP];
  logic [DW*IC*KK-1:0] x;
  logic [1:0] mode;
  logic [4:0] shift;
  logic [OP*IC*DW-1:0] w;
  logic [OP*ACC-1:0] b;
  logic signed [2*DW-1:0] prod;
  logic signed [ACC:0] r, rnd;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  pe_conv_mac_stream_wmem #(
    .pDATA_WIDTH(pDATA_WIDTH), .pIN_CHANNEL(pIN_CHANNEL), .pOUT_CHANNEL(pOUT_CHANNEL),
    .pKERNEL_SIZE(pKERNEL_SIZE), .pOUTPUT_PARALLEL(pOUTPUT_PARALLEL),
    .pWEIGHT_DATA_WIDTH(pWEIGHT_DATA_WIDTH), .pWEIGHT_BASE_ADDR(pWEIGHT_BASE_ADDR),
    .pACC_WIDTH(pACC_WIDTH), .GW(GW), .PW(PW)
  ) u_wmem (
    .clk(clk), .we(load_weight && state == IDLE), .waddr(weight_addr), .wdata(weight_data),
    .g(g), .p(p), .w(w), .b(b)
  );
  // rounding and clamping run one bit wider than the accumulator so the round-up cannot wrap
  always_comb begin
    prod = '0;
    r = '0;
    rnd = '0;
    for (int o = 0; o < OP; o++) begin
      psum[o] = '0;
      for (int c = 0; c < IC; c++) begin
        prod = $signed(x[(int'(p)*IC+c)*DW +: DW]) * $signed(w[(o*IC+c)*DW +: DW]);
        psum[o] = psum[o] + ACC'(prod);
      end
      r = (ACC+1)'(acc[o] + $signed(b[o*ACC +: ACC]));
      rnd = quant_shift_zero(shift) ? r : (r + ((ACC+1)'(1) <<< (shift - 5'd1))) >>> shift;
      rnd = (mode == ACT_RELU && rnd < 0) ? '0 : rnd;
      res[o] = rnd > SMAX ? SMAX[DW-1:0] : rnd < SMIN ? SMIN[DW-1:0] : rnd[DW-1:0];
    end
  end
  function automatic logic quant_shift_zero(input logic [4:0] s);
    return s == 5'd0;
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g <= '0;
      p <= '0;
      out_valid <= 1'b0;
      data_out <= '0;
      x <= '0;
      mode <= '0;
      shift <= '0;
      for (int o = 0; o < OP; o++) acc[o] <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x <= data_in;
          mode <= act_mode;
          shift <= quant_shift;
          g <= '0;
          p <= '0;
          for (int o = 0; o < OP; o++) acc[o] <= '0;
          state <= CALC;
        end
        CALC: begin
          for (int o = 0; o < OP; o++) acc[o] <= acc[o] + psum[o];
          p <= p == PW'(KK - 1) ? '0 : p + 1'b1;
          if (p == PW'(KK - 1)) state <= POST;
        end
        POST: begin
          for (int o = 0; o < OP; o++) begin
            data_out[(int'(g)*OP+o)*DW +: DW] <= res[o];
            acc[o] <= '0;
          end
          p <= '0;
          if (g == GW'(G - 1)) begin
            out_valid <= 1'b1;
            state <= OUT;
          end else begin
            g <= g + 1'b1;
            state <= CALC;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_conv_mac_stream.sv
// tb_pe_conv_mac_stream: directed vectors with queued expectations checked by an output monitor
module tb_pe_conv_mac_stream;
  localparam int DW = 8, IC = 1, K = 3, OC = 8, OP = 4, WW = 64, KK = 9, NW = 9;
  localparam logic [31:0] BASE = 32'h4000_0000;
  logic clk = 0, rst = 1, load_weight = 0, in_valid = 0, out_ready = 1;
  logic [31:0] weight_addr = '0;
  logic [WW-1:0] weight_data = '0;
  logic [1:0] act_mode = '0;
  logic [4:0] quant_shift = '0;
  logic [DW*IC*KK-1:0] data_in = '0;
  logic in_ready, out_valid, busy;
  logic [DW*OC-1:0] data_out;
  int cyc = 0, total = 0, bad = 0;
  logic [63:0] exp_q [$];
  int cyc_q [$];
  logic [7:0] wb [72];
  logic [31:0] bb [8];
  bit seen = 0;

  pe_conv_mac_stream #(
    .pDATA_WIDTH(DW), .pIN_CHANNEL(IC), .pOUT_CHANNEL(OC), .pKERNEL_SIZE(K),
    .pOUTPUT_PARALLEL(OP), .pWEIGHT_DATA_WIDTH(WW), .pWEIGHT_BASE_ADDR(BASE), .pACC_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .load_weight(load_weight), .weight_addr(weight_addr),
    .weight_data(weight_data), .act_mode(act_mode), .quant_shift(quant_shift),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // first cycle of each out_valid pulse is compared against the oldest expectation
  always @(negedge clk) begin
    if (out_valid && !seen) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h want none", data_out);
      end else begin
        chk("data_out", data_out, exp_q.pop_front());
        chk("first_valid_cycle", 64'(cyc), 64'(cyc_q.pop_front()));
      end
    end
    seen = out_valid;
  end

  task automatic load_word(input int off, input logic [63:0] d);
    @(negedge clk);
    load_weight = 1;
    weight_addr = BASE + off;
    weight_data = d;
    @(negedge clk);
    load_weight = 0;
  endtask

  task automatic program_mem();
    logic [63:0] d;
    for (int i = 0; i < NW; i++) begin
      for (int l = 0; l < 8; l++) d[l*8 +: 8] = wb[i*8+l];
      load_word(i, d);
    end
    for (int i = 0; i < 4; i++) load_word(NW + i, {bb[2*i+1], bb[2*i]});
  endtask

  task automatic set_all(input logic [7:0] wv, input logic [31:0] bv);
    for (int i = 0; i < 72; i++) wb[i] = wv;
    for (int o = 0; o < 8; o++) bb[o] = bv;
    program_mem();
  endtask

  task automatic send(input logic [71:0] win, input logic [1:0] m, input logic [4:0] s,
                      input logic [63:0] e, input bit push, output int acc_cyc);
    bit ok = 0;
    @(negedge clk);
    data_in = win;
    act_mode = m;
    quant_shift = s;
    in_valid = 1;
    for (int n = 0; n < 300 && !ok; n++) begin
      if (n > 0) @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    #1 in_valid = 0;
    acc_cyc = cyc;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept want accept");
    end else if (push) begin
      exp_q.push_back(e);
      cyc_q.push_back(acc_cyc + 20);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      ok = exp_q.size() == 0 && in_ready && !out_valid;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy want idle");
    end
  endtask

  function automatic logic [71:0] fill(input logic [7:0] v);
    return {9{v}};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int a, b2, hs;
    logic [71:0] win;
    logic [63:0] e;
    bit ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_data_out", data_out, 0);
    rst = 0;

    set_all(8'd1, 32'd0);
    send(fill(8'd2), 2'd0, 5'd0, {8{8'h12}}, 1, a);
    wait_idle();

    set_all(8'hFF, 32'd0);
    send(fill(8'd5), 2'd0, 5'd0, {8{8'hD3}}, 1, a);
    send(fill(8'd5), 2'd1, 5'd0, 64'd0, 1, a);
    send(fill(8'd5), 2'd2, 5'd0, {8{8'hD3}}, 1, a);
    wait_idle();

    set_all(8'h7F, 32'd0);
    send(fill(8'h7F), 2'd0, 5'd4, {8{8'h7F}}, 1, a);
    wait_idle();
    set_all(8'h80, 32'd0);
    send(fill(8'h7F), 2'd0, 5'd4, {8{8'h80}}, 1, a);
    wait_idle();

    // channel ch gets weight ch+1, exercising group/lane placement
    for (int i = 0; i < 72; i++) wb[i] = 8'((i / 36) * 4 + i % 4 + 1);
    for (int o = 0; o < 8; o++) bb[o] = 0;
    program_mem();
    for (int ch = 0; ch < 8; ch++) e[ch*8 +: 8] = 8'(9 * (ch + 1));
    send(fill(8'd1), 2'd0, 5'd0, e, 1, a);
    wait_idle();

    for (int i = 0; i < 72; i++) wb[i] = 8'd1;
    for (int o = 0; o < 8; o++) bb[o] = 32'(o);
    program_mem();
    for (int p = 0; p < 9; p++) win[p*8 +: 8] = 8'(p + 1);
    for (int ch = 0; ch < 8; ch++) e[ch*8 +: 8] = 8'(45 + ch);
    send(win, 2'd0, 5'd0, e, 1, a);
    for (int ch = 0; ch < 8; ch++) e[ch*8 +: 8] = 8'((45 + ch + 2) >> 2);
    send(win, 2'd0, 5'd2, e, 1, a);
    wait_idle();

    set_all(8'd1, 32'hFFFF_FFEC);
    send(fill(8'd2), 2'd0, 5'd0, {8{8'hFE}}, 1, a);
    send(fill(8'd2), 2'd1, 5'd0, 64'd0, 1, a);
    wait_idle();

    set_all(8'd1, 32'd0);
    out_ready = 0;
    fork
      begin
        send(fill(8'd2), 2'd0, 5'd0, {8{8'h12}}, 1, a);
        send(fill(8'd3), 2'd0, 5'd0, {8{8'h1B}}, 1, b2);
      end
      begin
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
          @(negedge clk);
          ok = out_valid;
        end
        chk("stall_reached_out", 64'(ok), 1);
        for (int n = 0; n < 10; n++) begin
          @(negedge clk);
          chk("stall_out_valid", 64'(out_valid), 1);
          chk("stall_data_out", data_out, {8{8'h12}});
          chk("stall_in_ready", 64'(in_ready), 0);
        end
        out_ready = 1;
        @(posedge clk);
        #1 hs = cyc;
        @(negedge clk);
        chk("hs_out_valid", 64'(out_valid), 0);
        chk("hs_data_hold", data_out, {8{8'h12}});
        chk("hs_in_ready", 64'(in_ready), 1);
      end
    join
    chk("accept_after_handshake", 64'(b2), 64'(hs + 1));
    wait_idle();

    send(fill(8'd2), 2'd0, 5'd0, 64'd0, 0, a);
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_out_valid", 64'(out_valid), 0);
    chk("midrst_in_ready", 64'(in_ready), 1);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_data_out", data_out, 0);
    send(fill(8'd2), 2'd0, 5'd0, {8{8'h12}}, 1, a);
    wait_idle();

    send(fill(8'd2), 2'd0, 5'd0, {8{8'h12}}, 1, a);
    load_word(0, 64'd0);
    wait_idle();
    load_word(NW + 100, 64'd0);
    load_word(-1, 64'd0);
    send(fill(8'd2), 2'd0, 5'd0, {8{8'h12}}, 1, a);
    wait_idle();

    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
